// File: rtl/dav_video_pkg.sv
// Shared video constants, cell-count helper and block-writer state type.
package dav_video_pkg;

    localparam int DEF_HPIXELS    = 640;
    localparam int DEF_VPIXELS    = 480;
    localparam int DEF_BLOCK_SIZE = 16;

    function automatic int cells_per_frame(input int hp, input int vp, input int bs);
        return (hp / bs) * (vp / bs);
    endfunction

    typedef enum logic [1:0] {
        WAIT_SOF,
        FILL,
        DONE
    } blk_wr_state_t;

endpackage

// File: rtl/block_stream_writer.sv
// Streams one colour per block cell into the double buffer write port, restarting at every frame swap.
// Optional statistics counters are enabled with `define BLOCK_WRITER_STATS_EN.
module block_stream_writer
    import dav_video_pkg::*;
#(
    parameter int         HPIXELS    = DEF_HPIXELS,
    parameter int         VPIXELS    = DEF_VPIXELS,
    parameter int         BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int         CELLS      = cells_per_frame(HPIXELS, VPIXELS, BLOCK_SIZE),
    parameter int         ADDR_W     = $clog2(CELLS),
    parameter logic [7:0] FILL_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
`ifdef BLOCK_WRITER_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    blk_wr_state_t     state;
    blk_wr_state_t     state_next;
    logic              swap;
    logic              accept;
    logic [ADDR_W-1:0] next_addr;

    assign swap   = (hc == 10'd0) && (vc == 10'd0);
    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    // A swap overrides everything, including a beat offered in the same cycle.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        if (swap) begin
            state_next = FILL;
        end else begin
            case (state)
                WAIT_SOF: state_next = WAIT_SOF;
                FILL: begin
                    s_ready = 1'b1;
                    if (s_valid && (next_addr == LAST_ADDR)) begin
                        state_next = DONE;
                    end
                end
                DONE:     state_next = DONE;
                default:  state_next = WAIT_SOF;
            endcase
        end
    end

    // The last cell parks the counter at LAST_ADDR instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_addr  <= '0;
            write_addr <= '0;
            wr_data    <= FILL_COLOR;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= swap && (state == FILL);
            if (swap) begin
                next_addr  <= '0;
                write_addr <= '0;
                wr_data    <= FILL_COLOR;
                frame_done <= 1'b0;
            end else if (accept) begin
                write_addr <= next_addr;
                wr_data    <= s_data;
                if (next_addr == LAST_ADDR) begin
                    frame_done <= 1'b1;
                end else begin
                    next_addr <= next_addr + 1'b1;
                end
            end
        end
    end

`ifdef BLOCK_WRITER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt    <= 16'h0000;
            underrun_cnt <= 16'h0000;
        end else begin
            if (swap && (state == DONE) && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end
            if (swap && (state == FILL) && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
